// File: rtl/game_pkg.sv
// Shared game constants, FSM state type and board-index helpers for the 2048 tile logic.
// Pure declarations; no latency or flow control.
package game_pkg;

  localparam int          TILE_W    = 21;
  localparam int          NUM_TILES = 16;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic [3:0] tile_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // One Galois step: shift right, fold the mask back in when a 1 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/tile_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR, one step per cycle; a load takes priority over the step.
// No flow control; a zero load value is replaced by SEED so the register never locks up.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);
  import game_pkg::*;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_val == 16'h0000) ? SEED : load_val;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/tile_spawner.sv
// Places a 2 or 4 in a random empty board cell: spawn_valid 1..16 cycles after an accepted start.
// No backpressure: start is taken only in IDLE, ignored while busy, and the write pulse is unconditional.
module tile_spawner #(
  parameter int          TILE_W      = 21,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          FOUR_THRESH = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [16*TILE_W-1:0] board,
  input  logic                 seed_load,
  input  logic [15:0]          seed_in,
  output logic                 busy,
  output logic                 spawn_valid,
  output logic [3:0]           spawn_idx,
  output logic [TILE_W-1:0]    spawn_val,
  output logic                 no_space
);
  import game_pkg::*;

  localparam logic [7:0] THRESH = 8'(FOUR_THRESH);

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         lfsr;
  logic [15:0]         empty;
  logic [15:0]         mask;
  logic [3:0]          pos;
  logic                four;
  logic                hit;
  logic                accept;
  logic [3:0]          idx_q;
  logic [TILE_W-1:0]   val_q;
  logic [TILE_W-1:0]   cur_val;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (lfsr)
  );

  // A tile counts as empty only when every bit of its value is zero.
  always_comb begin
    empty = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      empty[i] = (board[i*TILE_W +: TILE_W] == '0);
    end
  end

  assign accept  = (state == IDLE) && start;
  assign hit     = mask[pos];
  assign cur_val = four ? TILE_W'(4) : TILE_W'(2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && (empty != '0)) state_nxt = SCAN;
      SCAN: if (hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch from the pre-edge lfsr, so a same-cycle seed_load does not affect this spawn.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask     <= '0;
      pos      <= '0;
      four     <= 1'b0;
      no_space <= 1'b0;
      idx_q    <= '0;
      val_q    <= '0;
    end else begin
      if (accept) begin
        mask <= empty;
        pos  <= lfsr[3:0];
        four <= (lfsr[11:4] < THRESH);
        if (empty == '0) no_space <= 1'b1;
      end
      if (state == SCAN) begin
        if (hit) begin
          idx_q <= pos;
          val_q <= cur_val;
        end else begin
          pos <= pos + 4'd1;
        end
      end
    end
  end

  always_comb begin
    busy        = (state == SCAN);
    spawn_valid = (state == SCAN) && hit;
    spawn_idx   = spawn_valid ? pos : idx_q;
    spawn_val   = spawn_valid ? cur_val : val_q;
  end

endmodule

// File: tb/tb_tile_spawner.sv
// Directed-vector bench: the driver queues expected spawns, a negedge monitor checks each pulse.
module tb_tile_spawner;
  import game_pkg::*;

  localparam int TW = 21;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [16*TW-1:0]  board = '0;
  logic              seed_load = 1'b0;
  logic [15:0]       seed_in = '0;
  logic              busy;
  logic              spawn_valid;
  logic [3:0]        spawn_idx;
  logic [TW-1:0]     spawn_val;
  logic              no_space;

  tile_spawner dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .board       (board),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .busy        (busy),
    .spawn_valid (spawn_valid),
    .spawn_idx   (spawn_idx),
    .spawn_val   (spawn_val),
    .no_space    (no_space)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    idx;
    logic [TW-1:0] val;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Tiles flagged in emp are 0, others hold 2.
  function automatic logic [16*TW-1:0] mk_board(input logic [15:0] emp);
    logic [16*TW-1:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i*TW +: TW] = emp[i] ? TW'(0) : TW'(2);
    return b;
  endfunction

  // Monitor: every pulse must match the oldest expected spawn, including its cycle.
  always @(negedge clk) begin
    if (rst && spawn_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_spawn", {28'h0, spawn_idx}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("spawn_idx", {28'h0, spawn_idx}, {28'h0, e.idx});
        chk("spawn_val", 32'(spawn_val), 32'(e.val));
        chk("spawn_cycle", cyc, e.cyc);
        chk("busy_with_pulse", {31'h0, busy}, 32'h1);
      end
    end
  end

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Seed, then start on the next cycle; optionally queue the expected spawn.
  task automatic seeded_start(input logic [15:0] s, input logic [16*TW-1:0] b,
                              input bit push, input logic [3:0] idx,
                              input logic [TW-1:0] val, input int k);
    exp_t e;
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = s;
    board     = b;
    @(negedge clk);
    seed_load = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.idx = idx;
      e.val = val;
      e.cyc = cyc + k;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [15:0]      m;
    logic [16*TW-1:0] b;

    // Reset and free-running LFSR sequence
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m = 16'hACE1;
    chk("lfsr_reset", {16'h0, dut.u_lfsr.q}, {16'h0, m});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m = model_step(m);
      chk("lfsr_seq", {16'h0, dut.u_lfsr.q}, {16'h0, m});
      chk("idle_outputs", {27'h0, busy, spawn_valid, no_space, 2'b0} | 32'(spawn_idx) | 32'(spawn_val), 0);
    end

    // Empty board, pos 5, byte 0 -> immediate 4
    seeded_start(16'h0005, '0, 1'b1, 4'd5, TW'(4), 0);
    drain("drain_seed5");
    chk("hold_idx", {28'h0, spawn_idx}, 32'd5);
    chk("hold_val", 32'(spawn_val), 32'd4);

    // Threshold boundary: byte 25 -> 4, byte 26 -> 2
    seeded_start(16'h0190, '0, 1'b1, 4'd0, TW'(4), 0);
    drain("drain_b25");
    seeded_start(16'h01A0, '0, 1'b1, 4'd0, TW'(2), 0);
    drain("drain_b26");

    // Wrap search; tile 3 holds only a high bit and must count as occupied
    b = mk_board(16'h0002);
    b[3*TW +: TW] = TW'(21'h100000);
    seeded_start(16'h0FF3, b, 1'b1, 4'd1, TW'(2), 14);
    drain("drain_wrap");

    // Zero seed falls back to 16'hACE1: pos 1, byte 0xCE -> 2, wraps to tile 0
    seeded_start(16'h0000, mk_board(16'h0001), 1'b1, 4'd0, TW'(2), 15);
    drain("drain_zero_seed");

    // start with seed_load in the same cycle uses the pre-load value
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = 16'h0005;
    board     = '0;
    @(negedge clk);
    seed_in = 16'h0FF3;
    start   = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.idx = 4'd5; e.val = TW'(4); e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("lfsr_loaded", {16'h0, dut.u_lfsr.q}, 32'h0FF3);
    start = 1'b0;
    seed_load = 1'b0;
    drain("drain_same_cycle");

    // Extra start and board change mid-scan: one spawn from the latched mask
    seeded_start(16'h0001, mk_board(16'h0400), 1'b1, 4'd10, TW'(4), 9);
    chk("busy_scan", {31'h0, busy}, 32'h1);
    start = 1'b1;
    board = '0;
    @(negedge clk);
    start = 1'b0;
    drain("drain_midscan");
    chk("busy_after", {31'h0, busy}, 32'h0);

    // Full board: sticky no_space, no spawn, stays idle
    seeded_start(16'h1234, mk_board(16'h0000), 1'b0, 4'd0, '0, 0);
    chk("no_space_set", {31'h0, no_space}, 32'h1);
    chk("full_not_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_space_sticky", {31'h0, no_space}, 32'h1);

    // Reset mid-scan abandons the search
    seeded_start(16'h0000, mk_board(16'h0001), 1'b0, 4'd0, '0, 0);
    repeat (4) @(negedge clk);
    chk("busy_before_rst", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_no_space", {31'h0, no_space}, 32'h0);
    chk("rst_lfsr", {16'h0, dut.u_lfsr.q}, 32'hACE1);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
